// File: rtl/prog_mem_loader_if.sv
// Bus bundle for prog_mem_loader: streaming programming port, load status and fetch port.
// The master modport belongs to whoever programs and fetches; the slave modport belongs to the memory.
interface prog_mem_loader_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              prog_start;
    logic              prog_valid;
    logic [DATA_W-1:0] prog_data;
    logic              prog_last;
    logic              prog_ready;
    logic              loaded;
    logic [ADDR_W:0]   words_loaded;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_err;

    modport master (
        output prog_start, prog_valid, prog_data, prog_last, rd_en, rd_addr,
        input  prog_ready, loaded, words_loaded, rd_data, rd_valid, rd_err
    );

    modport slave (
        input  prog_start, prog_valid, prog_data, prog_last, rd_en, rd_addr,
        output prog_ready, loaded, words_loaded, rd_data, rd_valid, rd_err
    );
endinterface

// File: rtl/prog_mem_loader.sv
// Run-time loadable program memory: an IDLE/LOAD/RUN FSM streams an image in, then serves
// one-cycle-latency fetches, flagging any fetch outside the currently loaded image.
module prog_mem_loader #(
    parameter int              DATA_W = 8,
    parameter int              DEPTH  = 16,
    parameter int              ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter logic [DATA_W-1:0] FILL = '0
) (
    input logic               clk,
    input logic               rst_n,
    prog_mem_loader_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] wptr_q;
    logic [ADDR_W:0]   words_q;
    logic              prog_ready_q;
    logic              loaded_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;
    logic              rd_err_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic wr_en;
    logic last_word;
    logic fetch_ok;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        wr_en     = 1'b0;
        last_word = 1'b0;
        fetch_ok  = 1'b0;
        if (state_q == LOAD && !bus.prog_start) begin
            wr_en     = bus.prog_valid;
            last_word = bus.prog_last || (wptr_q == ADDR_W'(DEPTH - 1));
        end
        // words_q never exceeds DEPTH, so an accepted address is always inside the array.
        if (state_q == RUN && !bus.prog_start) begin
            fetch_ok = ({1'b0, bus.rd_addr} < words_q);
        end
    end

    // NOTE: the storage array has no reset; words_q=0 after reset already makes it unreadable.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wptr_q] <= bus.prog_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wptr_q       <= '0;
            words_q      <= '0;
            prog_ready_q <= 1'b0;
            loaded_q     <= 1'b0;
            rd_data_q    <= FILL;
            rd_valid_q   <= 1'b0;
            rd_err_q     <= 1'b0;
        end else begin
            if (bus.prog_start) begin
                state_q      <= LOAD;
                wptr_q       <= '0;
                words_q      <= '0;
                prog_ready_q <= 1'b1;
                loaded_q     <= 1'b0;
            end else if (wr_en) begin
                wptr_q  <= wptr_q + ADDR_W'(1);
                words_q <= words_q + (ADDR_W + 1)'(1);
                if (last_word) begin
                    state_q      <= RUN;
                    prog_ready_q <= 1'b0;
                    loaded_q     <= 1'b1;
                end
            end

            // A fetch during prog_start, IDLE or LOAD is rejected like an out-of-range one.
            rd_valid_q <= bus.rd_en && fetch_ok;
            rd_err_q   <= bus.rd_en && !fetch_ok;
            if (bus.rd_en) begin
                rd_data_q <= fetch_ok ? mem_q[bus.rd_addr] : FILL;
            end
        end
    end

    assign bus.prog_ready   = prog_ready_q;
    assign bus.loaded       = loaded_q;
    assign bus.words_loaded = words_q;
    assign bus.rd_data      = rd_data_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.rd_err       = rd_err_q;
endmodule

// File: tb/tb_prog_mem_loader.sv
// Bench for prog_mem_loader: a DEPTH=16 and a DEPTH=12 instance share one stimulus stream and
// are compared every cycle against an image-list model, plus directed literal expectations.
module tb_prog_mem_loader;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int NDUT   = 2;
    localparam logic [DATA_W-1:0] FILL = '0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              prog_start = 1'b0;
    logic              prog_valid = 1'b0;
    logic [DATA_W-1:0] prog_data  = '0;
    logic              prog_last  = 1'b0;
    logic              rd_en      = 1'b0;
    logic [ADDR_W-1:0] rd_addr    = '0;

    prog_mem_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) b0 ();
    prog_mem_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) b1 ();

    assign b0.prog_start = prog_start;
    assign b0.prog_valid = prog_valid;
    assign b0.prog_data  = prog_data;
    assign b0.prog_last  = prog_last;
    assign b0.rd_en      = rd_en;
    assign b0.rd_addr    = rd_addr;
    assign b1.prog_start = prog_start;
    assign b1.prog_valid = prog_valid;
    assign b1.prog_data  = prog_data;
    assign b1.prog_last  = prog_last;
    assign b1.rd_en      = rd_en;
    assign b1.rd_addr    = rd_addr;

    prog_mem_loader #(.DATA_W(DATA_W), .DEPTH(16), .FILL(FILL)) u_d16 (
        .clk(clk), .rst_n(rst_n), .bus(b0.slave));
    prog_mem_loader #(.DATA_W(DATA_W), .DEPTH(12), .FILL(FILL)) u_d12 (
        .clk(clk), .rst_n(rst_n), .bus(b1.slave));

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: an image is the list of words accepted since the last prog_start.
    int                depth_of [NDUT] = '{16, 12};
    logic [DATA_W-1:0] img      [NDUT][16];
    int                cnt      [NDUT];
    bit                loading  [NDUT];
    bit                running  [NDUT];
    logic              exp_valid [NDUT];
    logic              exp_err   [NDUT];
    logic [DATA_W-1:0] exp_data  [NDUT];

    task automatic model_reset(input int d);
        cnt[d] = 0; loading[d] = 0; running[d] = 0;
        exp_valid[d] = 0; exp_err[d] = 0; exp_data[d] = FILL;
    endtask

    task automatic model_step(input int d);
        bit ok;
        ok = running[d] && !prog_start && (int'(rd_addr) < cnt[d]);
        exp_valid[d] = rd_en && ok;
        exp_err[d]   = rd_en && !ok;
        if (rd_en) exp_data[d] = ok ? img[d][rd_addr] : FILL;
        if (prog_start) begin
            loading[d] = 1; running[d] = 0; cnt[d] = 0;
        end else if (loading[d] && prog_valid) begin
            img[d][cnt[d]] = prog_data;
            cnt[d]++;
            if (prog_last || cnt[d] == depth_of[d]) begin
                loading[d] = 0; running[d] = 1;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < NDUT; d++) begin
            if (!rst_n) model_reset(d);
            else        model_step(d);
        end
    end

    task automatic compare_one(input string p, input logic ready, input logic ld,
                               input logic [ADDR_W:0] wl, input logic [DATA_W-1:0] rdata,
                               input logic rv, input logic re, input int d);
        check({p, ".prog_ready"},   32'(ready), 32'(loading[d]));
        check({p, ".loaded"},       32'(ld),    32'(running[d]));
        check({p, ".words_loaded"}, 32'(wl),    32'(cnt[d]));
        check({p, ".rd_data"},      32'(rdata), 32'(exp_data[d]));
        check({p, ".rd_valid"},     32'(rv),    32'(exp_valid[d]));
        check({p, ".rd_err"},       32'(re),    32'(exp_err[d]));
    endtask

    always @(negedge clk) begin
        compare_one("d16", b0.prog_ready, b0.loaded, b0.words_loaded, b0.rd_data,
                    b0.rd_valid, b0.rd_err, 0);
        compare_one("d12", b1.prog_ready, b1.loaded, b1.words_loaded, b1.rd_data,
                    b1.rd_valid, b1.rd_err, 1);
    end

    // Inputs change 1ns after the falling edge, clear of both the compare and the DUT edge.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        prog_start = 0; prog_valid = 0; prog_last = 0; rd_en = 0;
    endtask

    task automatic start_load();
        idle_inputs();
        prog_start = 1;
        tick();
        prog_start = 0;
    endtask

    task automatic send(input logic [DATA_W-1:0] w, input logic last);
        prog_valid = 1; prog_data = w; prog_last = last;
        tick();
        prog_valid = 0; prog_last = 0;
    endtask

    task automatic fetch(input logic [ADDR_W-1:0] a);
        rd_en = 1; rd_addr = a;
        tick();
        rd_en = 0;
    endtask

    logic [DATA_W-1:0] wbuf [16];
    logic [DATA_W-1:0] img4 [4];

    initial begin
        img4[0] = 8'h10; img4[1] = 8'h30; img4[2] = 8'h40; img4[3] = 8'h40;
        repeat (3) tick();
        rst_n = 1;
        tick();
        check("rst.loaded", 32'(b0.loaded), 0);
        check("rst.words", 32'(b0.words_loaded), 0);
        check("rst.ready", 32'(b0.prog_ready), 0);

        fetch(0);
        check("idle_rd.err", 32'(b0.rd_err), 1);
        check("idle_rd.valid", 32'(b0.rd_valid), 0);
        check("idle_rd.data", 32'(b0.rd_data), 0);

        start_load();
        check("load.ready", 32'(b0.prog_ready), 1);
        for (int i = 0; i < 4; i++) send(img4[i], i == 3);
        check("img4.loaded", 32'(b0.loaded), 1);
        check("img4.words", 32'(b0.words_loaded), 4);
        check("img4.ready", 32'(b0.prog_ready), 0);
        for (int i = 0; i < 4; i++) begin
            rd_en = 1; rd_addr = ADDR_W'(i);
            tick();
            check($sformatf("img4.rd%0d.data", i), 32'(b0.rd_data), 32'(img4[i]));
            check($sformatf("img4.rd%0d.valid", i), 32'(b0.rd_valid), 1);
        end
        rd_en = 0;
        fetch(5);
        check("oob5.err", 32'(b0.rd_err), 1);
        check("oob5.data", 32'(b0.rd_data), 0);
        fetch(15);
        check("d12.oob15.err", 32'(b1.rd_err), 1);

        start_load();
        for (int i = 0; i < 16; i++) begin
            wbuf[i] = DATA_W'($urandom);
            send(wbuf[i], 1'b0);
        end
        check("full.words", 32'(b0.words_loaded), 16);
        check("full.loaded", 32'(b0.loaded), 1);
        check("d12.full.words", 32'(b1.words_loaded), 12);
        send(8'hA5, 1'b0);
        check("full.extra.words", 32'(b0.words_loaded), 16);
        fetch(0);
        check("full.rd0", 32'(b0.rd_data), 32'(wbuf[0]));
        fetch(15);
        check("full.rd15", 32'(b0.rd_data), 32'(wbuf[15]));
        check("d12.full.rd15.err", 32'(b1.rd_err), 1);
        fetch(11);
        check("d12.full.rd11", 32'(b1.rd_data), 32'(wbuf[11]));
        check("d12.full.rd11.valid", 32'(b1.rd_valid), 1);

        prog_start = 1; rd_en = 1; rd_addr = 0;
        tick();
        idle_inputs();
        check("start_rd.err", 32'(b0.rd_err), 1);
        check("start_rd.ready", 32'(b0.prog_ready), 1);
        check("start_rd.words", 32'(b0.words_loaded), 0);
        send(8'h5A, 1'b0);
        send(8'hC3, 1'b1);
        fetch(2);
        check("img2.rd2.err", 32'(b0.rd_err), 1);
        fetch(1);
        check("img2.rd1", 32'(b0.rd_data), 32'h C3);

        start_load();
        for (int i = 0; i < 3; i++) send(DATA_W'(8'h70 + i), 1'b0);
        rst_n = 0;
        tick();
        check("midrst.loaded", 32'(b0.loaded), 0);
        check("midrst.ready", 32'(b0.prog_ready), 0);
        check("midrst.words", 32'(b0.words_loaded), 0);
        rst_n = 1;
        tick();
        fetch(0);
        check("midrst.rd.err", 32'(b0.rd_err), 1);
        start_load();
        for (int i = 0; i < 6; i++) begin
            wbuf[i] = DATA_W'($urandom);
            send(wbuf[i], i == 5);
        end
        check("img6.words", 32'(b0.words_loaded), 6);
        for (int i = 0; i < 6; i++) begin
            fetch(ADDR_W'(i));
            check($sformatf("img6.rd%0d", i), 32'(b0.rd_data), 32'(wbuf[i]));
        end

        // Random traffic, checked by the per-cycle compare process.
        for (int n = 0; n < 3000; n++) begin
            prog_start = ($urandom_range(0, 39) == 0);
            prog_valid = $urandom_range(0, 1) == 1;
            prog_data  = DATA_W'($urandom);
            prog_last  = ($urandom_range(0, 9) == 0);
            rd_en      = $urandom_range(0, 1) == 1;
            rd_addr    = ADDR_W'($urandom);
            rst_n      = ($urandom_range(0, 499) != 0);
            tick();
        end
        idle_inputs();
        rst_n = 1;
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
